// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/LS memory port arbiter: FSM states, owner tags
// and a helper for sizing small counters.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_STATE_IDLE  = 2'd0,
    ARB_STATE_ISSUE = 2'd1,
    ARB_STATE_WAIT  = 2'd2,
    ARB_STATE_RESP  = 2'd3
  } arb_state_e;

  localparam logic ARB_OWNER_IF = 1'b0;
  localparam logic ARB_OWNER_LS = 1'b1;

  // Bits needed to hold the values 0..n, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational IF/LS grant with a registered anti-starvation streak counter.
// Handshake: a requester is accepted in the cycle its valid and its ready are both high.
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_LS_STREAK = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic idle_i,
  input  logic if_valid_i,
  input  logic if_flush_i,
  input  logic ls_valid_i,
  output logic grant_if_o,
  output logic grant_ls_o
);

  localparam int SW = cnt_width(MAX_LS_STREAK);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_LS_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          if_starved;

  always_comb begin
    if_starved = if_valid_i && !if_flush_i && (streak_q == MAX_S);
    grant_ls_o = idle_i && ls_valid_i && !if_starved;
    grant_if_o = idle_i && if_valid_i && !if_flush_i && !grant_ls_o;
  end

  // A flushed IF request is not a waiting requester, so an LS grant under
  // flush leaves the streak where it is.
  always_comb begin
    streak_d = streak_q;
    if (grant_ls_o) begin
      if (if_flush_i) begin
        streak_d = streak_q;
      end else if (if_valid_i) begin
        streak_d = (streak_q == MAX_S) ? streak_q : streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end else if (grant_if_o) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and
// load/store, one transaction in flight, LS priority with IF anti-starvation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int MAX_LS_STREAK = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int LW = cnt_width(MEM_LATENCY);
  localparam logic [LW-1:0] LAT = LW'(MEM_LATENCY);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              drop_q, drop_d;
  logic              idle, grant_if, grant_ls, accept;

  assign idle   = (state_q == ARB_STATE_IDLE);
  assign accept = grant_if || grant_ls;

  mem_arb_grant #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_grant (
    .clk       (clk),
    .reset_n   (reset_n),
    .idle_i    (idle),
    .if_valid_i(if_req_valid),
    .if_flush_i(if_flush),
    .ls_valid_i(ls_req_valid),
    .grant_if_o(grant_if),
    .grant_ls_o(grant_ls)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_STATE_IDLE:  if (accept) state_d = ARB_STATE_ISSUE;
      ARB_STATE_ISSUE: state_d = we_q ? ARB_STATE_RESP : ARB_STATE_WAIT;
      ARB_STATE_WAIT:  if (lat_q == LAT) state_d = ARB_STATE_RESP;
      ARB_STATE_RESP:  state_d = ARB_STATE_IDLE;
      default:         state_d = ARB_STATE_IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    drop_d  = drop_q;
    case (state_q)
      ARB_STATE_IDLE: begin
        drop_d = 1'b0;
        if (accept) begin
          owner_d = grant_ls ? ARB_OWNER_LS : ARB_OWNER_IF;
          we_d    = grant_ls && ls_req_we;
          addr_d  = grant_ls ? ls_req_addr : if_req_addr;
          wdata_d = grant_ls ? ls_req_wdata : '0;
        end
      end
      ARB_STATE_ISSUE: begin
        lat_d   = LW'(1);
        rdata_d = '0;
      end
      ARB_STATE_WAIT: begin
        lat_d = lat_q + LW'(1);
        if (lat_q == LAT) rdata_d = mem_rdata;
      end
      default: ;
    endcase
    // A branch anywhere after an IF accept kills that fetch's response.
    if (!idle && owner_q == ARB_OWNER_IF && if_flush) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= ARB_OWNER_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    if_req_ready = reset_n && grant_if;
    ls_req_ready = reset_n && grant_ls;
    mem_en       = (state_q == ARB_STATE_ISSUE);
    mem_we       = mem_en && we_q;
    mem_addr     = mem_en ? addr_q : '0;
    mem_wdata    = mem_we ? wdata_q : '0;
    if_rsp_valid = (state_q == ARB_STATE_RESP) && (owner_q == ARB_OWNER_IF) && !drop_q && !if_flush;
    if_rsp_data  = if_rsp_valid ? rdata_q : '0;
    ls_rsp_valid = (state_q == ARB_STATE_RESP) && (owner_q == ARB_OWNER_LS);
    ls_rsp_data  = ls_rsp_valid ? rdata_q : '0;
    busy         = !idle;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: grant table, directed corner sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int MAXS = 2;

  logic          clk, reset_n;
  logic          if_req_valid, if_req_ready, if_flush, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid, ls_req_we, ls_req_ready, ls_rsp_valid;
  logic [AW-1:0] ls_req_addr;
  logic [DW-1:0] ls_req_wdata, ls_rsp_data;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .MAX_LS_STREAK(MAXS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // single-port memory, one cycle read latency
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hE3A0_0001;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
      else mem_rdata <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_val(mem_addr);
    end
  end

  // checker
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0; ls_req_wdata = '0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) check("wait_idle", 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic if_v; logic if_f; logic ls_v; logic exp_if_rdy; logic exp_ls_rdy;
  } vec_t;
  vec_t vt [8];

  // scoreboard for the random run
  logic [DW-1:0] exp_q [$];
  int            exp_cyc_q [$];
  bit            exp_ls_q [$];
  bit            exp_drop_q [$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  bit order [$];
  bit exp_order3 [6] = '{1, 1, 0, 1, 1, 0};
  int en_cnt;

  initial begin
    reset_n = 1'b0;
    drive_idle();
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_mem_en", mem_en, 1'b0);
    check("reset_state", dbg_state, 2'd0);
    do_reset();
    check("post_reset_rsp", {if_rsp_valid, ls_rsp_valid, mem_we}, 3'b000);

    // grant table with streak at zero: {if_v, if_f, ls_v} -> {if_rdy, ls_rdy}
    vt[0] = '{0, 0, 0, 0, 0};
    vt[1] = '{0, 0, 1, 0, 1};
    vt[2] = '{0, 1, 0, 0, 0};
    vt[3] = '{0, 1, 1, 0, 1};
    vt[4] = '{1, 0, 0, 1, 0};
    vt[5] = '{1, 0, 1, 0, 1};
    vt[6] = '{1, 1, 0, 0, 0};
    vt[7] = '{1, 1, 1, 0, 1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if_req_valid = vt[i].if_v; if_flush = vt[i].if_f; ls_req_valid = vt[i].ls_v;
      #1;
      check($sformatf("tbl%0d_if_ready", i), if_req_ready, vt[i].exp_if_rdy);
      check($sformatf("tbl%0d_ls_ready", i), ls_req_ready, vt[i].exp_ls_rdy);
      drive_idle();
    end

    // IF read alone
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    #1 check("s1_if_ready", if_req_ready, 1'b1);
    @(posedge clk); #1 drive_idle();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("s1_mem_en_k%0d", k), mem_en, k == 1);
      check($sformatf("s1_if_rsp_k%0d", k), if_rsp_valid, k == 3);
      check($sformatf("s1_busy_k%0d", k), busy, k <= 3);
      if (k == 1) check("s1_mem_addr", {mem_we, mem_addr}, {1'b0, 32'h100});
      if (k == 3) check("s1_if_data", if_rsp_data, 32'hE3A0_0001);
    end

    // LS store
    @(negedge clk);
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h200; ls_req_wdata = 32'hDEAD_BEEF;
    #1 check("s2_ls_ready", ls_req_ready, 1'b1);
    @(posedge clk); #1 drive_idle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("s2_mem_we_k%0d", k), {mem_en, mem_we}, (k == 1) ? 2'b11 : 2'b00);
      check($sformatf("s2_ls_rsp_k%0d", k), ls_rsp_valid, k == 2);
      if (k == 1) check("s2_mem_bus", {mem_addr, mem_wdata}, {32'h200, 32'hDEAD_BEEF});
      if (k == 2) check("s2_ls_data", ls_rsp_data, 32'h0);
    end

    // both requesting continuously
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h300;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h400;
    order.delete();
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (if_req_ready && ls_req_ready) check("s3_both_ready", 1'b1, 1'b0);
      if (ls_req_ready) order.push_back(1'b1);
      else if (if_req_ready) order.push_back(1'b0);
    end
    @(posedge clk); #1 drive_idle();
    check("s3_grant_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      check($sformatf("s3_grant%0d_is_ls", i), order[i], exp_order3[i]);
    wait_idle();

    // IF read, flush during WAIT
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h104;
    #1 check("s4_if_ready", if_req_ready, 1'b1);
    @(posedge clk); #1 drive_idle();
    en_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if_flush = (k == 2);
      #1;
      if (k == 2) check("s4_in_wait", dbg_state, 2'd2);
      if (mem_en) en_cnt++;
      check($sformatf("s4_if_rsp_k%0d", k), if_rsp_valid, 1'b0);
    end
    if_flush = 1'b0;
    check("s4_mem_en_count", en_cnt, 1);

    // flush in IDLE with both valid leaves the streak alone
    @(negedge clk);
    if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h408;
    #1 check("s5_pre_ls_ready", ls_req_ready, 1'b1);
    @(posedge clk); #1 drive_idle();
    wait_idle();
    if_req_valid = 1'b1; ls_req_valid = 1'b1; if_flush = 1'b1; ls_req_addr = 32'h40C;
    #1;
    check("s5_flush_if_ready", if_req_ready, 1'b0);
    check("s5_flush_ls_ready", ls_req_ready, 1'b1);
    @(posedge clk); #1 drive_idle();
    wait_idle();
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    order.delete();
    for (int c = 0; c < 30 && order.size() < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (ls_req_ready) order.push_back(1'b1);
      else if (if_req_ready) order.push_back(1'b0);
    end
    @(posedge clk); #1 drive_idle();
    check("s5_grant_count", order.size(), 2);
    if (order.size() == 2) begin
      check("s5_grant0_is_ls", order[0], 1'b1);
      check("s5_grant1_is_ls", order[1], 1'b0);
    end
    wait_idle();

    // reset during WAIT
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h108;
    @(posedge clk); #1 drive_idle();
    @(negedge clk);
    @(negedge clk);
    check("s6_in_wait", dbg_state, 2'd2);
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check("s6_rst_outs", {busy, mem_en, mem_we, if_rsp_valid, ls_rsp_valid, if_req_ready, ls_req_ready},
          7'b0);
    check("s6_rst_buses", {mem_addr, mem_wdata}, 64'h0);
    check("s6_rst_state", dbg_state, 2'd0);
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("s6_no_rsp_%0d", k), {if_rsp_valid, ls_rsp_valid, busy}, 3'b000);
    end
    reset_n = 1'b1;
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    #1 check("s6_if_ready", if_req_ready, 1'b1);
    @(posedge clk); #1 drive_idle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("s6_if_rsp_k%0d", k), if_rsp_valid, k == 3);
      if (k == 3) check("s6_if_data", if_rsp_data, 32'hE3A0_0001);
    end

    // randomized run against a transaction-level model
    do_reset();
    begin
      int  cyc = 0, free_cyc = 0, run = 0, lat;
      bit  if_pend = 0, ls_pend = 0, m_ls, m_if, e_if_v, e_ls_v;
      logic [DW-1:0] e_d, d;
      for (cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        if (!if_pend && cyc < 2980 && $urandom_range(0, 2) == 0) begin
          if_pend = 1;
          if_req_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
        end
        if (!ls_pend && cyc < 2980 && $urandom_range(0, 2) == 0) begin
          ls_pend = 1;
          ls_req_we = 1'($urandom_range(0, 1));
          ls_req_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
          ls_req_wdata = $urandom;
        end
        if_req_valid = if_pend;
        ls_req_valid = ls_pend;
        if_flush = ($urandom_range(0, 7) == 0);
        #1;
        if (exp_q.size() > 0 && !exp_ls_q[0] && if_flush) exp_drop_q[0] = 1;
        e_if_v = 0; e_ls_v = 0; e_d = '0;
        if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
          e_d = exp_q[0];
          if (exp_ls_q[0]) e_ls_v = 1;
          else e_if_v = !exp_drop_q[0];
          void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front());
          void'(exp_ls_q.pop_front()); void'(exp_drop_q.pop_front());
        end
        check("rnd_if_rsp_valid", if_rsp_valid, e_if_v);
        check("rnd_ls_rsp_valid", ls_rsp_valid, e_ls_v);
        if (e_if_v) check("rnd_if_rsp_data", if_rsp_data, e_d);
        if (e_ls_v) check("rnd_ls_rsp_data", ls_rsp_data, e_d);
        m_ls = (cyc >= free_cyc) && ls_pend && !(if_pend && run == MAXS && !if_flush);
        m_if = (cyc >= free_cyc) && if_pend && !if_flush && !m_ls;
        check("rnd_if_ready", if_req_ready, m_if);
        check("rnd_ls_ready", ls_req_ready, m_ls);
        if (m_ls) begin
          if (ls_req_we) begin
            ref_mem[ls_req_addr] = ls_req_wdata;
            d = '0; lat = 2;
          end else begin
            d = ref_mem.exists(ls_req_addr) ? ref_mem[ls_req_addr] : init_val(ls_req_addr);
            lat = LAT + 2;
          end
          if (if_flush) run = run;
          else if (if_pend) run = (run < MAXS) ? run + 1 : run;
          else run = 0;
          ls_pend = 0;
          exp_q.push_back(d); exp_cyc_q.push_back(cyc + lat);
          exp_ls_q.push_back(1); exp_drop_q.push_back(0);
          free_cyc = cyc + lat + 1;
        end else if (m_if) begin
          d = ref_mem.exists(if_req_addr) ? ref_mem[if_req_addr] : init_val(if_req_addr);
          lat = LAT + 2;
          run = 0;
          if_pend = 0;
          exp_q.push_back(d); exp_cyc_q.push_back(cyc + lat);
          exp_ls_q.push_back(0); exp_drop_q.push_back(0);
          free_cyc = cyc + lat + 1;
        end
      end
      check("rnd_queue_drained", exp_q.size(), 0);
    end
    drive_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
